addsub_share_ctrl: RTL and testbench

Two-requester round-robin sequencer that time-shares one 16-bit add/sub datapath (`adder_16bit_s`) between two clients. Each client makes a request through a req/ack handshake. The block:
- arbitrates between clients,
- latches the winner's operands and operation,
- runs the shared datapath,
- returns sum, carry and signed overflow with a one-cycle ack.

It sits between the two client units and the single arithmetic resource.

---
 rtl/addsub_share_pkg.sv | 16 +
 rtl/adder_16bit_s.sv | 28 ++
 rtl/addsub_rr_arb2.sv | 18 +
 rtl/addsub_share_ctrl.sv | 130 +++++++++++++
 tb/tb_addsub_share_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/addsub_share_pkg.sv
// Shared types and constants for the two-client add/sub sequencer.
package addsub_share_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic        OP_ADD   = 1'b0;
  localparam logic        OP_SUB   = 1'b1;
  localparam int          ADDSUB_W = 16;
  localparam logic [15:0] SAT_POS  = 16'h7FFF;
  localparam logic [15:0] SAT_NEG  = 16'h8000;

endpackage

// File: rtl/adder_16bit_s.sv
// 16-bit add/sub datapath: S = A + B, or A + ~B + 1 when Add_ctrl is set.
// Reports carry out and two's-complement overflow of the selected operation.
module adder_16bit_s
  import addsub_share_pkg::*;
(
  input  logic [ADDSUB_W-1:0] A,
  input  logic [ADDSUB_W-1:0] B,
  input  logic                Add_ctrl,
  output logic [ADDSUB_W-1:0] S,
  output logic                C_out,
  output logic                O
);

  logic [ADDSUB_W-1:0] b_eff;
  logic [ADDSUB_W:0]   full;

  // Invert B and inject the carry-in for subtraction; overflow when the
  // effective operands agree in sign and the result does not.
  always_comb begin
    b_eff = (Add_ctrl == OP_SUB) ? ~B : B;
    full  = {1'b0, A} + {1'b0, b_eff} + {{ADDSUB_W{1'b0}}, Add_ctrl};
    S     = full[ADDSUB_W-1:0];
    C_out = full[ADDSUB_W];
    O     = (A[ADDSUB_W-1] == b_eff[ADDSUB_W-1]) &&
            (full[ADDSUB_W-1] != A[ADDSUB_W-1]);
  end

endmodule

// File: rtl/addsub_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to prio.
module addsub_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // One-hot grant; gnt_id is the index of the granted client (0 when idle).
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Round-robin sequencer sharing one adder_16bit_s between two req/ack clients.
// IDLE latches the winner's operands, EXEC registers the datapath result,
// RESP pulses the winner's ack and hands priority to the other client.
// Optional macro ADDSUB_SHARE_SAT_EN: saturate rsp_sum on signed overflow.
module addsub_share_ctrl
  import addsub_share_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub0,
  input  logic             sub1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);

  state_t           state, state_nxt;
  logic             prio;
  logic             gnt_id_q;
  logic [1:0]       gnt;
  logic             gnt_id;

  logic [WIDTH-1:0] a_p0, b_p0;
  logic             sub_p0;

  logic [WIDTH-1:0] dp_sum;
  logic             dp_cout;
  logic             dp_ovf;

  // Clamp to the signed extreme in the direction of A's sign on overflow.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] raw,
                                               input logic             ovf,
                                               input logic             a_msb);
`ifdef ADDSUB_SHARE_SAT_EN
    if (ovf) begin
      return a_msb ? SAT_NEG : SAT_POS;
    end
    return raw;
`else
    logic unused_sat;
    unused_sat = ovf ^ a_msb;
    return raw;
`endif
  endfunction

  addsub_rr_arb2 u_arb (
    .req    ({req1, req0}),
    .prio   (prio),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  adder_16bit_s u_adder (
    .A        (a_p0),
    .B        (b_p0),
    .Add_ctrl (sub_p0),
    .S        (dp_sum),
    .C_out    (dp_cout),
    .O        (dp_ovf)
  );

  // Control state: FSM, round-robin pointer and the id of the served client.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      prio     <= 1'b0;
      gnt_id_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && gnt != 2'b00) begin
        gnt_id_q <= gnt_id;
      end
      if (state == S_RESP) begin
        prio <= ~gnt_id_q;
      end
    end
  end

  // Next state: one grant walks IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt != 2'b00) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: capture the winner's operands; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && gnt != 2'b00) begin
      a_p0   <= gnt_id ? a1 : a0;
      b_p0   <= gnt_id ? b1 : b0;
      sub_p0 <= gnt_id ? sub1 : sub0;
    end
  end

  // Stage p1: register the datapath result; it holds until the next EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (state == S_EXEC) begin
      rsp_sum  <= sat_sum(dp_sum, dp_ovf, a_p0[WIDTH-1]);
      rsp_cout <= dp_cout;
      rsp_ovf  <= dp_ovf;
    end
  end

  // Ack pulses only during RESP, to exactly one client.
  always_comb begin
    ack0 = (state == S_RESP) && !gnt_id_q;
    ack1 = (state == S_RESP) &&  gnt_id_q;
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl: reset, single clients, alternation,
// operand capture and reset abort, with hand-computed expectations.
module tb_addsub_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, sub0, sub1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1, rsp_cout, rsp_ovf, busy;
  logic [15:0] rsp_sum;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ADDSUB_SHARE_SAT_EN
  localparam logic [15:0] EXP_T1 = 16'h7FFF;
  localparam logic [15:0] EXP_T3 = 16'h8000;
`else
  localparam logic [15:0] EXP_T1 = 16'h8000;
  localparam logic [15:0] EXP_T3 = 16'h7FFF;
`endif

  addsub_share_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sub0(sub0), .sub1(sub1),
    .ack0(ack0), .ack1(ack1),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    n_cmp++;
    if ({ack0, ack1, busy, rsp_cout, rsp_ovf} !== 5'b0 || rsp_sum !== 16'h0) begin
      n_bad++;
      $display("FAIL reset: ack0=%b ack1=%b busy=%b cout=%b ovf=%b sum=%h, want all 0",
               ack0, ack1, busy, rsp_cout, rsp_ovf, rsp_sum);
    end
    rst = 1'b0;
  endtask

  // Issue one request from a single client and check the response 2 cycles later.
  task automatic run_single(input string nm, input logic cl, input logic [15:0] a,
                            input logic [15:0] b, input logic sub,
                            input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
    if (cl) begin req1 = 1; a1 = a; b1 = b; sub1 = sub; end
    else    begin req0 = 1; a0 = a; b0 = b; sub0 = sub; end
    tick();
    n_cmp++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_exec: ack0=%b ack1=%b busy=%b, want 0 0 1", nm, ack0, ack1, busy);
    end
    tick();
    n_cmp++;
    if (ack0 !== ~cl || ack1 !== cl || rsp_sum !== e_sum ||
        rsp_cout !== e_cout || rsp_ovf !== e_ovf) begin
      n_bad++;
      $display("FAIL %s_resp: ack0=%b ack1=%b sum=%h cout=%b ovf=%b, want ack%0d sum=%h cout=%b ovf=%b",
               nm, ack0, ack1, rsp_sum, rsp_cout, rsp_ovf, cl, e_sum, e_cout, e_ovf);
    end
    req0 = 0; req1 = 0;
    tick();
    n_cmp++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || rsp_sum !== e_sum) begin
      n_bad++;
      $display("FAIL %s_idle: ack0=%b ack1=%b busy=%b sum=%h, want 0 0 0 %h",
               nm, ack0, ack1, busy, rsp_sum, e_sum);
    end
  endtask

  task automatic test_single();
    run_single("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, EXP_T1, 1'b0, 1'b1);
    run_single("sub_borrow", 1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_single("sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b1, EXP_T3, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic e0, e1;
    rst = 1'b1;
    req0 = 1; a0 = 16'd1; b0 = 16'd2; sub0 = 0;
    req1 = 1; a1 = 16'd5; b1 = 16'd3; sub1 = 1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e0 = ((k % 6) == 2);
      e1 = ((k % 6) == 5);
      n_cmp++;
      if (ack0 !== e0 || ack1 !== e1) begin
        n_bad++;
        $display("FAIL b2b_ack_c%0d: ack0=%b ack1=%b, want %b %b", k, ack0, ack1, e0, e1);
      end
      if (e0 || e1) begin
        n_cmp++;
        if (rsp_sum !== (e0 ? 16'h0003 : 16'h0002)) begin
          n_bad++;
          $display("FAIL b2b_sum_c%0d: sum=%h, want %h", k, rsp_sum, e0 ? 16'h0003 : 16'h0002);
        end
      end
    end
    req0 = 0; req1 = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_capture();
    req0 = 1; a0 = 16'h0003; b0 = 16'h0004; sub0 = 0;
    tick();
    a0 = 16'hFFFF; b0 = 16'hFFFF; req0 = 0;
    tick();
    n_cmp++;
    if (ack0 !== 1'b1 || rsp_sum !== 16'h0007 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL capture: ack0=%b sum=%h cout=%b ovf=%b, want 1 0007 0 0",
               ack0, rsp_sum, rsp_cout, rsp_ovf);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || ack0 !== 1'b0) begin
      n_bad++;
      $display("FAIL capture_idle: busy=%b ack0=%b, want 0 0", busy, ack0);
    end
  endtask

  task automatic test_reset_abort();
    req1 = 1; a1 = 16'd10; b1 = 16'd3; sub1 = 1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ack0, ack1, busy, rsp_cout, rsp_ovf} !== 5'b0 || rsp_sum !== 16'h0) begin
      n_bad++;
      $display("FAIL abort_reset: ack0=%b ack1=%b busy=%b cout=%b ovf=%b sum=%h, want all 0",
               ack0, ack1, busy, rsp_cout, rsp_ovf, rsp_sum);
    end
    tick();
    n_cmp++;
    if (ack1 !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_exec: ack1=%b busy=%b, want 0 1", ack1, busy);
    end
    tick();
    n_cmp++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0 || rsp_sum !== 16'h0007 || rsp_cout !== 1'b1 || rsp_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_resp: ack0=%b ack1=%b sum=%h cout=%b ovf=%b, want 0 1 0007 1 0",
               ack0, ack1, rsp_sum, rsp_cout, rsp_ovf);
    end
    req1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_capture();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
